// File: rtl/fp_addsub_pipe_if.sv
// Stream interface for fp_addsub_pipe: operand handshake in, result handshake out.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_nan;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_nan
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_nan
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: align, add, normalise, round/pack.
// Fixed 3-cycle latency, one op per cycle, whole pipe stalls on output backpressure.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic             clk,
  input logic             rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;          // hidden, fraction, guard, round, sticky
  localparam int LZ_W = $clog2(SW + 1);
  localparam int XW   = EXP_W + LZ_W + 2;   // signed exponent with headroom both ways

  localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
  localparam logic signed [XW-1:0] ONE_X     = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] ZERO_X    = '0;
  localparam logic signed [XW-1:0] EXP_MAX_X = {{(XW-EXP_W){1'b0}}, EXP_ONES};
  localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- unpack / align ----------------
  logic             sa, sb, sx;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb, fx, fy;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [SW-1:0]    x_full, y_full, y_al;
  logic             stk;
  logic             spec_n, nan_n;
  logic [W-1:0]     spec_res_n;

  assign sa     = bus.op_a[W-1];
  assign sb     = bus.op_b[W-1] ^ bus.sub;
  assign ea     = bus.op_a[W-2:MAN_W];
  assign eb     = bus.op_b[W-2:MAN_W];
  assign fa     = bus.op_a[MAN_W-1:0];
  assign fb     = bus.op_b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign swap   = bus.op_b[W-2:0] > bus.op_a[W-2:0];
  assign sx     = swap ? sb : sa;
  assign ex     = swap ? eb : ea;
  assign fx     = swap ? fb : fa;
  assign ey     = swap ? ea : eb;
  assign fy     = swap ? fa : fb;
  assign d      = ex - ey;
  assign x_full = {1'b1, fx, 3'b000};
  assign y_full = {1'b1, fy, 3'b000};

  always_comb begin
    stk  = 1'b0;
    y_al = '0;
    if (int'(d) >= SW - 1) begin
      y_al = {{(SW-1){1'b0}}, 1'b1};
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (i < int'(d)) stk = stk | y_full[i];
      end
      y_al    = y_full >> d;
      y_al[0] = y_al[0] | stk;
    end
  end

  // NaN, infinity and zero operands bypass the arithmetic entirely
  always_comb begin
    spec_n     = 1'b1;
    nan_n      = 1'b0;
    spec_res_n = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      nan_n      = 1'b1;
      spec_res_n = QNAN;
    end else if (a_inf) begin
      spec_res_n = bus.op_a;
    end else if (b_inf) begin
      spec_res_n = {sb, bus.op_b[W-2:0]};
    end else if (a_zero && b_zero) begin
      spec_res_n = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res_n = {sb, bus.op_b[W-2:0]};
    end else if (b_zero) begin
      spec_res_n = bus.op_a;
    end else begin
      spec_n = 1'b0;
    end
  end

  // ---------------- stage registers ----------------
  logic                    v1, spec1, nan1, sign1, esub1;
  logic [EXP_W-1:0]        e1;
  logic [SW-1:0]           x1, y1;
  logic [W-1:0]            sres1;
  logic                    v2, spec2, nan2, sign2;
  logic [EXP_W-1:0]        e2;
  logic [SW:0]             sum2;
  logic [W-1:0]            sres2;
  logic                    v3, spec3, nan3, sign3, zero3;
  logic signed [XW-1:0]    e3;
  logic [SW-1:0]           man3;
  logic [W-1:0]            sres3;

  // ---------------- normalise ----------------
  int                      lzi;
  logic                    found;
  logic [LZ_W-1:0]         lz;
  logic signed [XW-1:0]    e2x, lzx, e_n;
  logic [SW-1:0]           man_n;
  logic                    zero_n;

  always_comb begin
    lzi   = 0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum2[i]) found = 1'b1;
        else         lzi++;
      end
    end
    lz     = LZ_W'(lzi);
    e2x    = {{(XW-EXP_W){1'b0}}, e2};
    lzx    = {{(XW-LZ_W){1'b0}}, lz};
    zero_n = (sum2 == '0);
    if (sum2[SW]) begin
      man_n = {sum2[SW:2], sum2[1] | sum2[0]};
      e_n   = e2x + ONE_X;
    end else begin
      man_n = sum2[SW-1:0] << lz;
      e_n   = e2x - lzx;
    end
  end

  // ---------------- round / pack ----------------
  logic                 inc;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] e_r;
  logic [W-1:0]         res_n;
  logic                 ovf_n, unf_n, rnan_n;

  always_comb begin
    inc    = man3[2] & (man3[3] | man3[1] | man3[0]);
    mant_r = {1'b0, man3[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    e_r    = mant_r[MAN_W+1] ? e3 + ONE_X : e3;
    frac_r = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    res_n  = {sign3, e_r[EXP_W-1:0], frac_r};
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    rnan_n = 1'b0;
    if (spec3) begin
      res_n  = sres3;
      rnan_n = nan3;
    end else if (zero3) begin
      res_n = '0;
    end else if (e_r >= EXP_MAX_X) begin
      res_n = {sign3, EXP_ONES, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (e_r <= ZERO_X) begin
      res_n = {sign3, {(W-1){1'b0}}};
      unf_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flag_ovf  <= 1'b0;
      bus.flag_unf  <= 1'b0;
      bus.flag_nan  <= 1'b0;
    end else if (adv) begin
      v1    <= bus.in_valid;
      spec1 <= spec_n;
      nan1  <= nan_n;
      sres1 <= spec_res_n;
      sign1 <= sx;
      esub1 <= sa ^ sb;
      e1    <= ex;
      x1    <= x_full;
      y1    <= y_al;

      v2    <= v1;
      spec2 <= spec1;
      nan2  <= nan1;
      sres2 <= sres1;
      sign2 <= sign1;
      e2    <= e1;
      sum2  <= esub1 ? ({1'b0, x1} - {1'b0, y1}) : ({1'b0, x1} + {1'b0, y1});

      v3    <= v2;
      spec3 <= spec2;
      nan3  <= nan2;
      sres3 <= sres2;
      sign3 <= sign2;
      zero3 <= zero_n;
      e3    <= e_n;
      man3  <= man_n;

      bus.out_valid <= v3;
      bus.result    <= res_n;
      bus.flag_ovf  <= ovf_n;
      bus.flag_unf  <= unf_n;
      bus.flag_nan  <= rnan_n;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: FP16 and FP32 instances, latency, specials,
// backpressure stability and mid-flight reset.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();
  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) s_if ();

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(h_if));
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .bus(s_if));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic [2:0]  f;   // {ovf, unf, nan}
  } vec_h_t;

  vec_h_t vh[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vh(input string t, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] r, input logic [2:0] f);
    vec_h_t v;
    v.tag = t; v.a = a; v.b = b; v.s = s; v.r = r; v.f = f;
    vh.push_back(v);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge the result shows.
  task automatic run_h(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] er, input logic [2:0] ef);
    int lat;
    h_if.out_ready = 1'b1;
    h_if.in_valid  = 1'b1;
    h_if.op_a      = a;
    h_if.op_b      = b;
    h_if.sub       = s;
    @(posedge clk); #1;
    h_if.in_valid = 1'b0;
    lat = 0;
    while (!h_if.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_res"}, 64'(h_if.result), 64'(er));
    check({tag, "_flg"}, 64'({h_if.flag_ovf, h_if.flag_unf, h_if.flag_nan}), 64'(ef));
  endtask

  task automatic run_s(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] er, input logic [2:0] ef);
    int lat;
    s_if.out_ready = 1'b1;
    s_if.in_valid  = 1'b1;
    s_if.op_a      = a;
    s_if.op_b      = b;
    s_if.sub       = s;
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    lat = 0;
    while (!s_if.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_res"}, 64'(s_if.result), 64'(er));
    check({tag, "_flg"}, 64'({s_if.flag_ovf, s_if.flag_unf, s_if.flag_nan}), 64'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          sent, recv;
    logic [15:0] held;
    logic        hold_chk;

    rst = 1'b1;
    h_if.in_valid = 1'b0; h_if.op_a = '0; h_if.op_b = '0; h_if.sub = 1'b0; h_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.op_a = '0; s_if.op_b = '0; s_if.sub = 1'b0; s_if.out_ready = 1'b0;

    add_vh("add",       16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);
    add_vh("sub",       16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000);
    add_vh("cancel",    16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
    add_vh("tie_even",  16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000);
    add_vh("tie_up",    16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b000);
    add_vh("ovf",       16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100);
    add_vh("inf_nan",   16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001);
    add_vh("inf_pass",  16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000);
    add_vh("subnorm",   16'h0001, 16'h3C00, 1'b0, 16'h3C00, 3'b000);
    add_vh("unf",       16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b010);
    add_vh("unf_neg",   16'h8401, 16'h0400, 1'b0, 16'h8000, 3'b010);
    add_vh("nan_in",    16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b001);
    add_vh("zero_zero", 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000);
    add_vh("zero_a",    16'h0000, 16'h3C00, 1'b1, 16'hBC00, 3'b000);
    add_vh("inf_sub",   16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b001);
    add_vh("carry",     16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
    add_vh("carry_nrm", 16'h3BFF, 16'h1000, 1'b0, 16'h3C00, 3'b000);
    add_vh("rnd_carry", 16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 3'b000);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", 64'(h_if.out_valid), 64'd0);
    check("rst_result", 64'(h_if.result), 64'd0);
    check("rst_flags",  64'({h_if.flag_ovf, h_if.flag_unf, h_if.flag_nan}), 64'd0);
    check("rst_iready", 64'(h_if.in_ready), 64'd1);
    check("rst_s_ovalid", 64'(s_if.out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_iready", 64'(h_if.in_ready), 64'd1);

    foreach (vh[i]) run_h(vh[i].tag, vh[i].a, vh[i].b, vh[i].s, vh[i].r, vh[i].f);
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure: 8 ops back-to-back, out_ready pattern 1,0,0,1
    sent = 0; recv = 0; hold_chk = 1'b0; held = '0;
    for (int c = 0; c < 200 && recv < 8; c++) begin
      h_if.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      h_if.in_valid  = (sent < 8);
      if (sent < 8) begin
        h_if.op_a = vh[sent].a;
        h_if.op_b = vh[sent].b;
        h_if.sub  = vh[sent].s;
      end
      @(negedge clk);
      check("bp_iready", 64'(h_if.in_ready), 64'(!(h_if.out_valid && !h_if.out_ready)));
      if (hold_chk) check("bp_hold", 64'({h_if.out_valid, h_if.result}), 64'({1'b1, held}));
      hold_chk = h_if.out_valid && !h_if.out_ready;
      held     = h_if.result;
      if (h_if.out_valid && h_if.out_ready && recv < 8) begin
        check($sformatf("bp_res%0d", recv), 64'(h_if.result), 64'(vh[recv].r));
        recv++;
      end
      if (h_if.in_valid && h_if.in_ready) sent++;
      @(posedge clk); #1;
    end
    h_if.in_valid  = 1'b0;
    h_if.out_ready = 1'b1;
    check("bp_count", 64'(recv), 64'd8);
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_no_extra", 64'(h_if.out_valid), 64'd0);
    end

    // Reset with two operations in flight
    h_if.in_valid = 1'b1;
    h_if.op_a = vh[0].a; h_if.op_b = vh[0].b; h_if.sub = vh[0].s;
    @(posedge clk); #1;
    h_if.op_a = vh[1].a; h_if.op_b = vh[1].b; h_if.sub = vh[1].s;
    @(posedge clk); #1;
    h_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_quiet", 64'(h_if.out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_h("after_rst", 16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000);

    // Single precision
    run_s("s_add",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    run_s("s_sub",      32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    run_s("s_cancel",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    run_s("s_tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run_s("s_tie_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    run_s("s_ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    run_s("s_nan",      32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
